// File: rtl/hvac_pkg.sv
`default_nettype none
// ============================================================================
// Package  : hvac_pkg
// Purpose  : Shared widths, default thresholds and FSM/mode encodings for the
//            HVAC zone scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package hvac_pkg;

  localparam int TEMP_W = 5;

  localparam int DEF_NUM_ZONES  = 4;
  localparam int DEF_HEAT_TH    = 18;
  localparam int DEF_COOL_TH    = 22;
  localparam int DEF_TARGET     = 20;
  localparam int DEF_MIN_DWELL  = 8;
  localparam int DEF_MAX_DWELL  = 32;
  localparam int DEF_GAP_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  typedef enum logic {
    HEAT = 1'b0,
    COOL = 1'b1
  } mode_t;

endpackage
`default_nettype wire

// File: rtl/hvac_zone_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker; first set request at or after
//            ptr (wrapping) wins.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    pick  = '0;
    idx   = '0;
    valid = 1'b0;
    for (int off = 0; off < N; off++) begin
      int j;
      j = int'(ptr) + off;
      if (j >= N) j = j - N;
      if (!valid && req[j]) begin
        valid   = 1'b1;
        pick[j] = 1'b1;
        idx     = IW'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hvac_zone_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : hvac_zone_scheduler
// Purpose  : Time-shares one heat/cool plant between NUM_ZONES thermostat
//            zones with round-robin grants, minimum dwell and a dead gap.
//            Define HVAC_SCHED_PREEMPT_EN to enable MAX_DWELL preemption.
// Revision : 1.0 - initial release
// ============================================================================
module hvac_zone_scheduler
  import hvac_pkg::*;
#(
  parameter int NUM_ZONES  = DEF_NUM_ZONES,
  parameter int HEAT_TH    = DEF_HEAT_TH,
  parameter int COOL_TH    = DEF_COOL_TH,
  parameter int TARGET     = DEF_TARGET,
  parameter int MIN_DWELL  = DEF_MIN_DWELL,
  parameter int MAX_DWELL  = DEF_MAX_DWELL,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [TEMP_W*NUM_ZONES-1:0]   temp,
  input  logic [NUM_ZONES-1:0]          zone_en,
  output logic [NUM_ZONES-1:0]          grant,
  output logic                          heating,
  output logic                          cooling,
  output logic                          busy
);

  localparam int IW = $clog2(NUM_ZONES);
`ifdef HVAC_SCHED_PREEMPT_EN
  localparam int DWELL_CAP = MAX_DWELL;
`else
  localparam int DWELL_CAP = MIN_DWELL;
`endif
  localparam int DW = $clog2(DWELL_CAP + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [TEMP_W-1:0] c_HEAT_TH    = TEMP_W'(HEAT_TH);
  localparam logic [TEMP_W-1:0] c_COOL_TH    = TEMP_W'(COOL_TH);
  localparam logic [TEMP_W-1:0] c_TARGET     = TEMP_W'(TARGET);
  localparam logic [DW-1:0]     c_MIN_DWELL  = DW'(MIN_DWELL);
  localparam logic [DW-1:0]     c_DWELL_CAP  = DW'(DWELL_CAP);
  localparam logic [GW-1:0]     c_GAP_CYCLES = GW'(GAP_CYCLES);
  localparam logic [IW-1:0]     c_LAST_ZONE  = IW'(NUM_ZONES - 1);

  logic [TEMP_W-1:0]    w_temp [NUM_ZONES];
  logic [NUM_ZONES-1:0] w_demand;
  logic [NUM_ZONES-1:0] w_pick;
  logic [IW-1:0]        w_pick_idx;
  logic                 w_pick_valid;

  state_t               r_state, w_state_nxt;
  mode_t                r_mode, w_mode_nxt;
  logic [NUM_ZONES-1:0] r_grant, w_grant_nxt;
  logic                 r_heating, w_heating_nxt;
  logic                 r_cooling, w_cooling_nxt;
  logic                 r_busy, w_busy_nxt;
  logic [IW-1:0]        r_idx, w_idx_nxt;
  logic [IW-1:0]        r_ptr, w_ptr_nxt;
  logic [DW-1:0]        r_dwell, w_dwell_nxt;
  logic [GW-1:0]        r_gap, w_gap_nxt;

  logic                 w_sat;
  logic                 w_preempt;
  logic                 w_release;
  logic                 w_start;

  generate
    for (genvar i = 0; i < NUM_ZONES; i++) begin : g_zone
      assign w_temp[i]   = temp[i*TEMP_W +: TEMP_W];
      assign w_demand[i] = zone_en[i] && ((w_temp[i] < c_HEAT_TH) || (w_temp[i] > c_COOL_TH));
    end
  endgenerate

  rr_pick #(
    .N  (NUM_ZONES),
    .IW (IW)
  ) u_rr_pick (
    .req   (w_demand),
    .ptr   (r_ptr),
    .pick  (w_pick),
    .idx   (w_pick_idx),
    .valid (w_pick_valid)
  );

  // Satisfaction is judged against the mode latched at grant time.
  assign w_sat = (r_mode == HEAT) ? (w_temp[r_idx] >= c_TARGET)
                                  : (w_temp[r_idx] <= c_TARGET);

`ifdef HVAC_SCHED_PREEMPT_EN
  localparam logic [DW-1:0] c_MAX_DWELL = DW'(MAX_DWELL);
  assign w_preempt = (r_dwell >= c_MAX_DWELL) && (|(w_demand & ~r_grant));
`else
  assign w_preempt = 1'b0;
`endif

  assign w_release = (r_state == SERVE) &&
                     (!zone_en[r_idx] || ((r_dwell >= c_MIN_DWELL) && w_sat) || w_preempt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mode    <= HEAT;
      r_grant   <= '0;
      r_heating <= 1'b0;
      r_cooling <= 1'b0;
      r_busy    <= 1'b0;
      r_idx     <= '0;
      r_ptr     <= '0;
      r_dwell   <= '0;
      r_gap     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_mode    <= w_mode_nxt;
      r_grant   <= w_grant_nxt;
      r_heating <= w_heating_nxt;
      r_cooling <= w_cooling_nxt;
      r_busy    <= w_busy_nxt;
      r_idx     <= w_idx_nxt;
      r_ptr     <= w_ptr_nxt;
      r_dwell   <= w_dwell_nxt;
      r_gap     <= w_gap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = SERVE;
          w_start     = 1'b1;
        end
      end
      SERVE: begin
        if (w_release) w_state_nxt = GAP;
      end
      GAP: begin
        if (r_gap >= c_GAP_CYCLES) begin
          w_state_nxt = w_pick_valid ? SERVE : IDLE;
          w_start     = w_pick_valid;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath, derived from the
  // transition chosen above so every output lands on the same edge.
  always_comb begin
    w_grant_nxt = '0;
    w_idx_nxt   = r_idx;
    w_mode_nxt  = r_mode;
    w_ptr_nxt   = r_ptr;
    w_dwell_nxt = r_dwell;
    w_gap_nxt   = r_gap;
    if (w_start) begin
      w_grant_nxt = w_pick;
      w_idx_nxt   = w_pick_idx;
      w_mode_nxt  = (w_temp[w_pick_idx] < c_HEAT_TH) ? HEAT : COOL;
      w_dwell_nxt = DW'(1);
    end else if (w_release) begin
      w_ptr_nxt = (r_idx == c_LAST_ZONE) ? '0 : r_idx + IW'(1);
      w_gap_nxt = GW'(1);
    end else if (r_state == SERVE) begin
      w_grant_nxt = r_grant;
      if (r_dwell < c_DWELL_CAP) w_dwell_nxt = r_dwell + DW'(1);
    end else if (r_state == GAP) begin
      w_gap_nxt = r_gap + GW'(1);
    end
    w_heating_nxt = (w_state_nxt == SERVE) && (w_mode_nxt == HEAT);
    w_cooling_nxt = (w_state_nxt == SERVE) && (w_mode_nxt == COOL);
    w_busy_nxt    = (w_state_nxt != IDLE);
  end

  assign grant   = r_grant;
  assign heating = r_heating;
  assign cooling = r_cooling;
  assign busy    = r_busy;

endmodule
`default_nettype wire
